// File: rtl/csa_sub_256.sv
// csa_sub_256: limb-serial inverse of the 256-bit three-operand adder.
// Recovers a = s - b - c one LIMB_W-bit limb per clock, least significant limb
// first, and flags results that are negative (borrow) or need bit WIDTH (ovf).
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request; accepted in IDLE or DONE, ignored while running
//   s      - WIDTH+1 bit minuend (adder sum including its carry bit)
//   b, c   - WIDTH bit subtrahends
//   a      - (s - b - c) mod 2^WIDTH, valid while done is high
//   borrow - true result is negative
//   ovf    - true result is >= 2^WIDTH
//   done   - result valid (level, held until the next accepted start)
//   busy   - computation in progress
module csa_sub_256 #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned LIMB_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] a,
  output logic             borrow,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NLIMB = WIDTH / LIMB_W;
  localparam int unsigned IdxW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NLIMB - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;      // low WIDTH bits of s, shifted down a limb per cycle
  logic             s_top_q, s_top_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       bacc_q, bacc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Signed limb difference; three guard bits cover the range down to -2^(LIMB_W+1).
  logic [LIMB_W+2:0] diff;
  logic [1:0]        bacc_nxt;

  always_comb begin
    diff = {3'b000, s_q[LIMB_W-1:0]}
         - {3'b000, b_q[LIMB_W-1:0]}
         - {3'b000, c_q[LIMB_W-1:0]}
         - {{(LIMB_W + 1){1'b0}}, bacc_q};
    // The guard bits hold floor(d / 2^LIMB_W) in {0,-1,-2}; its negation is the new borrow.
    bacc_nxt = 2'(3'd0 - diff[LIMB_W+2:LIMB_W]);
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    s_top_d  = s_top_q;
    b_d      = b_q;
    c_d      = c_q;
    a_d      = a_q;
    bacc_d   = bacc_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          s_d      = s[WIDTH-1:0];
          s_top_d  = s[WIDTH];
          b_d      = b;
          c_d      = c;
          a_d      = '0;
          bacc_d   = 2'd0;
          idx_d    = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_d[idx_q*LIMB_W +: LIMB_W] = diff[LIMB_W-1:0];
        bacc_d = bacc_nxt;
        s_d    = s_q >> LIMB_W;
        b_d    = b_q >> LIMB_W;
        c_d    = c_q >> LIMB_W;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // top = s[WIDTH] - bacc, in {-2,-1,0,1}
          borrow_d = (bacc_nxt > {1'b0, s_top_q});
          ovf_d    = s_top_q && (bacc_nxt == 2'd0);
          idx_d    = '0;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      s_q      <= '0;
      s_top_q  <= 1'b0;
      b_q      <= '0;
      c_q      <= '0;
      a_q      <= '0;
      bacc_q   <= 2'd0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      s_top_q  <= s_top_d;
      b_q      <= b_d;
      c_q      <= c_d;
      a_q      <= a_d;
      bacc_q   <= bacc_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign a      = a_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q == StRun);

endmodule
